kbd_matrix_scanner: RTL and testbench

// - Scan initiator for the keyboard matrix: strobes one column high at a time on kbd_col,

---
 rtl/kbd_pkg.sv | 21 ++
 rtl/kbd_row_sync.sv | 24 ++
 rtl/kbd_matrix_scanner.sv | 177 +++++++++++++++++
 tb/tb_kbd_matrix_scanner.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared types and defaults for the keyboard matrix scanner.
package kbd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        SAMPLE  = 2'd2,
        COMPARE = 2'd3
    } scan_state_t;

    localparam int ROWS_DEF     = 9;
    localparam int COLS_DEF     = 10;
    localparam int SETTLE_DEF   = 2;
    localparam int DEBOUNCE_DEF = 4;

    // Flat bitmap position of the key at (row r, column c).
    function automatic int key_index(input int c, input int r, input int rows);
        return c * rows + r;
    endfunction

endpackage

// File: rtl/kbd_row_sync.sv
// Two-flop synchronizer bringing the asynchronous row pins into clk.
module kbd_row_sync #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the stable output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/kbd_matrix_scanner.sv
// Keyboard matrix scanner: strobes one column at a time, samples the rows,
// debounces whole frames and publishes a stable key bitmap.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no column driven, waiting for enable and a scan_tick
// DRIVE   | column col_idx driven, settling for SETTLE ticks
// SAMPLE  | one clk after the row sample; advance column or end frame
// COMPARE | one clk, no column driven; debounce the completed frame
module kbd_matrix_scanner
    import kbd_pkg::*;
#(
    parameter int ROWS     = ROWS_DEF,
    parameter int COLS     = COLS_DEF,
    parameter int SETTLE   = SETTLE_DEF,
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 scan_tick,
    input  logic [ROWS-1:0]      kbd_row,
    output logic [COLS-1:0]      kbd_col,
    output logic [ROWS*COLS-1:0] keys,
    output logic                 changed,
    input  logic                 ack,
    output logic                 frame_done
);

    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int WAIT_W = $clog2(SETTLE + 1);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE);
    localparam logic [3:0]        DEB_MAX   = 4'(DEBOUNCE);

    scan_state_t state_q, state_d;
    logic [COL_W-1:0]     col_idx_q, col_idx_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [ROWS-1:0]      row_sync;
    logic [ROWS*COLS-1:0] frame_q;
    logic [ROWS*COLS-1:0] prev_q;
    logic [3:0]           stable_q;
    logic [3:0]           stable_next;
    logic                 sample_en;
    logic                 commit;

    kbd_row_sync #(
        .WIDTH (ROWS)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (kbd_row),
        .dout  (row_sync)
    );

    // Rows are captured on the tick that ends the settle window.
    assign sample_en = (state_q == DRIVE) && scan_tick && (wait_cnt_q == '0);

    // FSM state, column pointer and settle down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_idx_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            col_idx_q  <= col_idx_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic; scan_tick is only consulted in IDLE and DRIVE.
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable && scan_tick) begin
                    state_d    = DRIVE;
                    col_idx_d  = '0;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            DRIVE: begin
                if (scan_tick) begin
                    if (wait_cnt_q == '0) begin
                        state_d = SAMPLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
            end
            SAMPLE: begin
                if (col_idx_q == COL_LAST) begin
                    state_d = COMPARE;
                end else begin
                    state_d    = DRIVE;
                    col_idx_d  = col_idx_q + 1'b1;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            COMPARE: begin
                col_idx_d = '0;
                if (enable) begin
                    state_d    = DRIVE;
                    wait_cnt_d = WAIT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                col_idx_d = '0;
            end
        endcase
    end

    // Column strobe decoded straight from flops so reset blanks it at once.
    always_comb begin
        kbd_col = '0;
        if (state_q == DRIVE || state_q == SAMPLE) begin
            for (int c = 0; c < COLS; c++) begin
                if (col_idx_q == COL_W'(c)) begin
                    kbd_col[c] = 1'b1;
                end
            end
        end
    end

    assign frame_done = (state_q == COMPARE);

    // Debounce counter value this COMPARE would produce, and the commit decision.
    always_comb begin
        stable_next = 4'd1;
        if (frame_q == prev_q) begin
            stable_next = (stable_q == DEB_MAX) ? stable_q : stable_q + 4'd1;
        end
        commit = (state_q == COMPARE) && (stable_next == DEB_MAX) && (frame_q != keys);
    end

    // Frame capture, debounce history, published bitmap and sticky change flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            keys     <= '0;
            changed  <= 1'b0;
        end else begin
            if (sample_en) begin
                for (int c = 0; c < COLS; c++) begin
                    if (col_idx_q == COL_W'(c)) begin
                        for (int r = 0; r < ROWS; r++) begin
                            frame_q[key_index(c, r, ROWS)] <= row_sync[r];
                        end
                    end
                end
            end
            if (state_q == COMPARE) begin
                stable_q <= stable_next;
                prev_q   <= frame_q;
            end
            if (commit) begin
                keys <= frame_q;
            end
            // A commit in the same clk as ack keeps the flag set.
            if (commit) begin
                changed <= 1'b1;
            end else if (ack) begin
                changed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kbd_matrix_scanner.sv
// Directed bench for kbd_matrix_scanner with a one-key matrix model.
module tb_kbd_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        scan_tick;
    logic [8:0]  kbd_row;
    logic [9:0]  kbd_col;
    logic [89:0] keys;
    logic        changed;
    logic        ack;
    logic        frame_done;
    logic        press;

    int n_cmp = 0;
    int n_bad = 0;

    logic [89:0] exp_keys;
    logic [9:0]  seen;
    int          nfr;
    int          fd_cnt;

    kbd_matrix_scanner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .scan_tick  (scan_tick),
        .kbd_row    (kbd_row),
        .kbd_col    (kbd_col),
        .keys       (keys),
        .changed    (changed),
        .ack        (ack),
        .frame_done (frame_done)
    );

    // Key (row 3) closes onto columns 8 and 9 while pressed.
    assign kbd_row = press ? {5'b0, (kbd_col[8] | kbd_col[9]), 3'b0} : 9'b0;

    always #5 clk = ~clk;

    // scan_tick: one clk wide, every 4 clks.
    initial begin
        scan_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 scan_tick = 1'b1;
            @(posedge clk);
            #1 scan_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [89:0] obs, input logic [89:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Returns at the negedge where frame_done is high.
    task automatic wait_fd();
        bit got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        assert (got) else begin
            n_bad++;
            $error("FAIL frame_done_timeout observed=%0d expected=1", got);
        end
    endtask

    task automatic run_frames(input int n);
        repeat (n) wait_fd();
    endtask

    task automatic wait_col(input logic [9:0] pat);
        bit got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (kbd_col === pat) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        assert (got) else begin
            n_bad++;
            $error("FAIL col_timeout observed=%0h expected=%0h", kbd_col, pat);
        end
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic count_to_commit();
        nfr = 0;
        for (int i = 0; i < 8; i++) begin
            wait_fd();
            nfr++;
            @(negedge clk);
            if (changed) break;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        ack      = 1'b0;
        press    = 1'b0;
        exp_keys = '0;
        exp_keys[75] = 1'b1;
        exp_keys[84] = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_kbd_col", kbd_col, 0);
        check("rst_keys", keys, 0);
        check("rst_changed", changed, 0);
        check("rst_frame_done", frame_done, 0);

        // Single press held from reset: commit on the 4th frame.
        rst_n  = 1'b1;
        enable = 1'b1;
        press  = 1'b1;
        count_to_commit();
        check("press_frames", nfr, 4);
        check("press_changed", changed, 1);
        check("press_keys", keys, exp_keys);
        pulse_ack();
        check("press_ack", changed, 0);

        // Bounce: 2 released frames then re-press; nothing commits.
        press = 1'b0;
        run_frames(2);
        check("bounce_keys_mid", keys, exp_keys);
        press = 1'b1;
        run_frames(5);
        check("bounce_changed", changed, 0);
        check("bounce_keys", keys, exp_keys);

        // Release: keys clear on the 4th released frame.
        press = 1'b0;
        run_frames(3);
        check("release_changed_early", changed, 0);
        check("release_keys_early", keys, exp_keys);
        wait_fd();
        @(negedge clk);
        check("release_keys", keys, 0);
        check("release_changed", changed, 1);
        pulse_ack();
        check("release_ack", changed, 0);

        // Ack in the same clk as a commit: the commit wins.
        press = 1'b1;
        run_frames(3);
        check("coll_changed_early", changed, 0);
        wait_fd();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("coll_changed", changed, 1);
        check("coll_keys", keys, exp_keys);
        pulse_ack();
        check("coll_ack", changed, 0);

        // Enable drop during column 4: frame finishes, then silence.
        wait_col(10'h010);
        enable = 1'b0;
        seen   = kbd_col;
        fd_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            seen = seen | kbd_col;
            if (frame_done) begin
                fd_cnt++;
                break;
            end
        end
        check("drop_cols", seen, 10'h3F0);
        check("drop_fd", fd_cnt, 1);
        check("drop_col_compare", kbd_col, 0);
        seen   = '0;
        fd_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            seen = seen | kbd_col;
            if (frame_done) fd_cnt++;
        end
        check("idle_cols", seen, 0);
        check("idle_fd", fd_cnt, 0);
        check("idle_keys", keys, exp_keys);

        // Reset during DRIVE of column 6.
        enable = 1'b1;
        wait_col(10'h040);
        check("prereset_keys", keys, exp_keys);
        rst_n = 1'b0;
        #1;
        check("midrst_kbd_col", kbd_col, 0);
        check("midrst_keys", keys, 0);
        check("midrst_changed", changed, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (kbd_col != 10'h000) begin
                seen = kbd_col;
                break;
            end
        end
        check("restart_col0", seen, 10'h001);
        count_to_commit();
        check("restart_frames", nfr, 4);
        check("restart_keys", keys, exp_keys);
        check("restart_changed", changed, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
